mips_cp0: RTL and testbench
===========================

// Module: mips_cp0
// PURPOSE
//  Coprocessor-0 for the pipelined CPU. Sits in M stage, consuming the 6-bit HWInt vector
//  built at top level ({3'b0, interrupt, TC1_IRQ, TC0_IRQ}) plus M-stage exception codes.
//  Holds SR/Cause/EPC/PRId, serves mfc0/mtc0, and decides the exception/interrupt request that
//  flushes the pipe and redirects fetch. Its request drives o_tb_Req / macroscopic PC.
// PARAMETERS
//  HANDLER_ADDR  32'h0000_4180  redirect target on request
//  PRID          32'h2022_0001  constant value returned for register 15
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-low reset (0 = reset)
//  i_addr       in   5   CP0 register index for mfc0/mtc0
//  i_we         in   1   mtc0 write enable (M stage)
//  i_wdata      in   32  mtc0 write data
//  o_rdata      out  32  mfc0 read data (combinational from i_addr)
//  i_vpc        in   32  M-stage PC of the victim instruction
//  i_bd         in   1   victim is in a branch delay slot
//  i_exccode    in   5   M-stage exception code, 0 = none
//  i_hwint      in   6   hardware interrupt lines
//  i_eret       in   1   eret in M stage
//  o_req        out  1   take exception/interrupt this cycle (flush + redirect)
//  o_epc        out  32  EPC for eret redirect (bypassed)
//  o_handler    out  32  HANDLER_ADDR
// BEHAVIOUR
//  - Registers: SR(12) = {IM[15:10], EXL[1], IE[0]}, other bits read 0.
//    Cause(13) = {BD[31], IP[15:10], ExcCode[6:2]}, other bits 0. EPC(14) 32b. PRId(15) = PRID.
//    Any other index reads 32'h0. All register state is 0 after reset.
//  - Reset (reset==0 at posedge): SR, Cause, EPC <= 0. o_req = 0 while SR=0 (IE=0).
//  - Cause.IP <= i_hwint every cycle, independent of all else (reset wins).
//  - int_req = |(i_hwint & SR.IM) & SR.IE & ~SR.EXL   (uses raw lines, not latched IP).
//  - exc_req = (i_exccode != 0) & ~SR.EXL.   o_req = int_req | exc_req (combinational).
//  - On o_req at posedge: EXL<=1; ExcCode <= int_req ? 0 : i_exccode (interrupt wins);
//    BD <= i_bd; EPC <= i_bd ? {i_vpc[31:2],2'b00}-4 : {i_vpc[31:2],2'b00}.
//    mtc0 in the same cycle is discarded (victim does not commit). i_eret same cycle ignored.
//  - i_eret (no o_req): EXL <= 0 at posedge. Takes priority over simultaneous mtc0 to SR.EXL;
//    mtc0 to other SR fields still applies.
//  - mtc0 (i_we, no o_req): addr 12 writes bits 15:10,1,0 only; addr 14 writes all 32 bits;
//    addr 13, 15 and others ignored.
//  - o_epc = (i_we & i_addr==14 & ~o_req) ? i_wdata : EPC (same-cycle bypass for eret).
//  - o_rdata reflects register state before this cycle's write (no write-through).
//  - Latency: request visible same cycle; register effects visible the next cycle.
//  - Nested: while EXL=1 no request of any kind; pending lines are held in IP only.
// TESTING
//  1 reset=0 2 cycles, hwint=6'h3F -> o_req=0; next cycle mfc0 13 = 32'h0000_FC00, SR=0.
//  2 mtc0 12 <= 32'h0000_0401; raise hwint[0] with i_vpc=32'h3008, bd=0 -> o_req=1 same cycle;
//    next: EPC=32'h3008, ExcCode=0, SR=32'h0000_0403, o_req=0 despite hwint still high.
//  3 exccode=5'd4, i_vpc=32'h3010, bd=1, no int -> o_req=1; EPC=32'h300C, Cause[31]=1, ExcCode=4.
//  4 hwint[1] enabled + exccode=5'd10 same cycle -> ExcCode=0 (interrupt priority), EPC=i_vpc.
//  5 mtc0 14 <= 32'h4000 with i_eret=1 same cycle -> o_epc=32'h4000; next: EXL=0, EPC=32'h4000.
//  6 reset=0 while EXL=1 and hwint active -> next cycle SR=Cause[6:2]=EPC=0, o_req=0.

Source files
------------

// File: rtl/mips_cp0.sv
// Coprocessor 0 for the pipelined CPU: holds SR/Cause/EPC/PRId, serves mfc0/mtc0 and
// raises the exception/interrupt request that flushes the pipe and redirects fetch.
module mips_cp0 #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h2022_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_addr,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic [31:0] i_vpc,
  input  logic        i_bd,
  input  logic [4:0]  i_exccode,
  input  logic [5:0]  i_hwint,
  input  logic        i_eret,
  output logic        o_req,
  output logic [31:0] o_epc,
  output logic [31:0] o_handler
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_vpc_aligned;
  logic [31:0] w_victim_epc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // Interrupt decision looks at the raw lines so a same-cycle edge is taken immediately.
  assign w_int_req     = (|(i_hwint & r_im)) & r_ie & ~r_exl;
  assign w_exc_req     = (i_exccode != 5'd0) & ~r_exl;
  assign w_req         = w_int_req | w_exc_req;
  assign w_vpc_aligned = {i_vpc[31:2], 2'b00};
  assign w_victim_epc  = i_bd ? (w_vpc_aligned - 32'd4) : w_vpc_aligned;

  assign w_sr    = {16'h0, r_im, 8'h0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'h0, r_ip, 3'h0, r_exccode, 2'b00};

  assign o_req     = w_req;
  assign o_handler = HANDLER_ADDR;
  assign o_epc     = (i_we && (i_addr == 5'd14) && !w_req) ? i_wdata : r_epc;

  always_comb begin
    o_rdata = 32'h0;
    case (i_addr)
      5'd12:   o_rdata = w_sr;
      5'd13:   o_rdata = w_cause;
      5'd14:   o_rdata = r_epc;
      5'd15:   o_rdata = PRID;
      default: o_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im      <= 6'h0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'h0;
      r_exccode <= 5'h0;
      r_epc     <= 32'h0;
    end else begin
      r_ip <= i_hwint;
      if (w_req) begin
        // The victim does not commit, so its mtc0 and any eret are dropped.
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? 5'd0 : i_exccode;
        r_bd      <= i_bd;
        r_epc     <= w_victim_epc;
      end else begin
        if (i_we && (i_addr == 5'd12)) begin
          r_im  <= i_wdata[15:10];
          r_exl <= i_wdata[1];
          r_ie  <= i_wdata[0];
        end
        if (i_we && (i_addr == 5'd14)) begin
          r_epc <= i_wdata;
        end
        if (i_eret) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_cp0.sv
// Scoreboard bench for mips_cp0: a word-level reference model predicts each cycle's
// outputs, a separate monitor compares them against the DUT.
module tb_mips_cp0;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID_V  = 32'h2022_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  i_addr = '0;
  logic        i_we = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic [31:0] i_vpc = '0;
  logic        i_bd = 1'b0;
  logic [4:0]  i_exccode = '0;
  logic [5:0]  i_hwint = '0;
  logic        i_eret = 1'b0;
  logic        o_req;
  logic [31:0] o_epc;
  logic [31:0] o_handler;

  mips_cp0 dut (
    .clk       (clk),
    .reset     (reset),
    .i_addr    (i_addr),
    .i_we      (i_we),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .i_vpc     (i_vpc),
    .i_bd      (i_bd),
    .i_exccode (i_exccode),
    .i_hwint   (i_hwint),
    .i_eret    (i_eret),
    .o_req     (o_req),
    .o_epc     (o_epc),
    .o_handler (o_handler)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] rd;
    logic [31:0] epc;
    int          kreq;
    longint      krd;
    longint      kep;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state as whole architectural words.
  logic [31:0] m_sr = 32'h0;
  logic [31:0] m_cause = 32'h0;
  logic [31:0] m_epc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] vpc, input logic bd,
                       input logic [4:0] exc, input logic [5:0] hw, input logic eret,
                       input int kreq = -1, input longint krd = -1, input longint kep = -1);
    exp_t e;
    logic int_r, exc_r, req;
    @(negedge clk);
    reset = rst; i_we = we; i_addr = addr; i_wdata = wdata; i_vpc = vpc;
    i_bd = bd; i_exccode = exc; i_hwint = hw; i_eret = eret;

    int_r = ((hw & m_sr[15:10]) != 6'h0) && m_sr[0] && !m_sr[1];
    exc_r = (exc != 5'd0) && !m_sr[1];
    req   = int_r || exc_r;
    e.req = req;
    case (addr)
      5'd12:   e.rd = m_sr;
      5'd13:   e.rd = m_cause;
      5'd14:   e.rd = m_epc;
      5'd15:   e.rd = PRID_V;
      default: e.rd = 32'h0;
    endcase
    e.epc  = (we && addr == 5'd14 && !req) ? wdata : m_epc;
    e.kreq = kreq; e.krd = krd; e.kep = kep;
    q.push_back(e);

    if (!rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = hw;
      if (req) begin
        m_sr[1]       = 1'b1;
        m_cause[6:2]  = int_r ? 5'd0 : exc;
        m_cause[31]   = bd;
        m_epc         = (vpc & ~32'd3) - (bd ? 32'd4 : 32'd0);
      end else begin
        if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
        if (we && addr == 5'd14) m_epc = wdata;
        if (eret) m_sr[1] = 1'b0;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("req", {31'h0, o_req}, {31'h0, e.req});
        check("rdata", o_rdata, e.rd);
        check("epc", o_epc, e.epc);
        check("handler", o_handler, HANDLER);
        if (e.kreq >= 0) check("req_const", {31'h0, o_req}, e.kreq[31:0]);
        if (e.krd >= 0)  check("rdata_const", o_rdata, e.krd[31:0]);
        if (e.kep >= 0)  check("epc_const", o_epc, e.kep[31:0]);
      end
    end
  end

  initial begin : stim
    int guard;
    // 1: reset holds requests off; Cause.IP follows the lines afterwards
    drive(0, 0, 13, 0, 0, 0, 0, 6'h3F, 0, 0);
    drive(0, 0, 13, 0, 0, 0, 0, 6'h3F, 0, 0, 0);
    drive(1, 0, 13, 0, 0, 0, 0, 6'h3F, 0, 0, 32'h0);
    drive(1, 0, 13, 0, 0, 0, 0, 6'h3F, 0, 0, 32'h0000_FC00);
    drive(1, 0, 12, 0, 0, 0, 0, 6'h3F, 0, 0, 32'h0);
    drive(1, 0, 15, 0, 0, 0, 0, 6'h00, 0, 0, PRID_V);
    drive(1, 0, 20, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0);
    // 2: interrupt on hwint[0]
    drive(1, 1, 12, 32'h0000_0401, 0, 0, 0, 6'h00, 0, 0);
    drive(1, 0, 12, 0, 32'h3008, 0, 0, 6'h01, 0, 1, 32'h0000_0401);
    drive(1, 0, 14, 0, 0, 0, 0, 6'h01, 0, 0, 32'h3008);
    drive(1, 0, 13, 0, 0, 0, 0, 6'h01, 0, 0, 32'h0000_0400);
    drive(1, 0, 12, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0000_0403);
    drive(1, 0, 12, 0, 0, 0, 0, 6'h00, 1, 0);
    // 3: exception in a delay slot
    drive(1, 0, 12, 0, 32'h3010, 1, 5'd4, 6'h00, 0, 1, 32'h0000_0401);
    drive(1, 0, 14, 0, 0, 0, 0, 6'h00, 0, 0, 32'h300C);
    drive(1, 0, 13, 0, 0, 0, 0, 6'h00, 1, 0, 32'h8000_0010);
    // 4: interrupt beats a simultaneous exception
    drive(1, 1, 12, 32'h0000_0C01, 0, 0, 0, 6'h00, 0, 0);
    drive(1, 0, 12, 0, 32'h3020, 0, 5'd10, 6'h02, 0, 1);
    drive(1, 0, 13, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0000_0800);
    drive(1, 0, 14, 0, 0, 0, 0, 6'h00, 0, 0, 32'h3020);
    // 5: mtc0 EPC bypass alongside eret
    drive(1, 1, 14, 32'h4000, 0, 0, 0, 6'h00, 1, 0, -1, 32'h4000);
    drive(1, 0, 12, 0, 0, 0, 0, 6'h00, 0, 0, 32'h0000_0C01);
    drive(1, 0, 14, 0, 0, 0, 0, 6'h00, 0, 0, 32'h4000);
    // 6: reset while in exception with lines active
    drive(1, 0, 12, 0, 32'h5000, 0, 0, 6'h02, 0, 1);
    drive(0, 0, 12, 0, 0, 0, 0, 6'h02, 0, 0);
    drive(1, 0, 12, 0, 0, 0, 0, 6'h02, 0, 0, 32'h0);
    drive(1, 0, 14, 0, 0, 0, 0, 6'h02, 0, 0, 32'h0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] a;
      logic [31:0] wd;
      a  = 5'($urandom_range(11, 16));
      if ($urandom_range(0, 9) == 0) a = 5'($urandom);
      wd = $urandom;
      if (a == 5'd12 && $urandom_range(0, 1) == 1) wd[1] = 1'b0;
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0), a, wd, $urandom,
            1'($urandom), ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0,
            ($urandom_range(0, 5) == 0));
    end
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #4;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
